fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; feeds DECODE_STAGE
//  (o_InstrD, o_PCPlus4D) and takes its redirect target (i_PCNextD) back. Owns the PC and a

---
 rtl/fetch_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register for the 5-stage MIPS pipeline.
// Owns the PC, drives a single-outstanding req/ack instruction memory, and buffers a response during a decode stall.
module fetch_stage #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                INSTR_WIDTH   = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter logic [INSTR_WIDTH-1:0]     NOP_INSTR     = '0
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_StallD,
  input  logic                     i_FlushD,
  input  logic                     i_PCSrcD,
  input  logic [ADDRESS_WIDTH-1:0] i_PCNextD,
  output logic                     o_IMemReq,
  output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
  input  logic                     i_IMemAck,
  input  logic [INSTR_WIDTH-1:0]   i_IMemRdata,
  output logic [INSTR_WIDTH-1:0]   o_InstrD,
  output logic [ADDRESS_WIDTH-1:0] o_PCPlus4D,
  output logic                     o_ValidD,
  output logic [ADDRESS_WIDTH-1:0] o_PCF
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] pc, pc_nxt;
  logic                     discard, discard_nxt;
  logic [INSTR_WIDTH-1:0]   buf_instr, buf_instr_nxt;
  logic [ADDRESS_WIDTH-1:0] buf_pc4, buf_pc4_nxt;
  logic [INSTR_WIDTH-1:0]   instr_d;
  logic [ADDRESS_WIDTH-1:0] pc4_d;
  logic                     valid_d;

  logic                     redirect;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     mem_req;
  logic                     deliver;
  logic [INSTR_WIDTH-1:0]   deliver_instr;
  logic [ADDRESS_WIDTH-1:0] deliver_pc4;

  // A stalled decode cannot act on its own branch decision.
  assign redirect = i_PCSrcD & ~i_StallD;
  assign pc_plus4 = pc + ADDRESS_WIDTH'(4);

  // Next-state, PC, discard tracking and delivery selection.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    discard_nxt   = discard;
    buf_instr_nxt = buf_instr;
    buf_pc4_nxt   = buf_pc4;
    mem_req       = 1'b0;
    deliver       = 1'b0;
    deliver_instr = i_IMemRdata;
    deliver_pc4   = pc_plus4;

    case (state)
      S_REQ: begin
        mem_req     = 1'b1;
        state_nxt   = S_WAIT;
        discard_nxt = redirect;
        if (redirect) pc_nxt = i_PCNextD;
      end
      S_WAIT: begin
        if (redirect) pc_nxt = i_PCNextD;
        if (!i_IMemAck) begin
          discard_nxt = discard | redirect;
        end else if (discard || redirect) begin
          discard_nxt = 1'b0;
          state_nxt   = S_REQ;
        end else if (i_StallD) begin
          buf_instr_nxt = i_IMemRdata;
          buf_pc4_nxt   = pc_plus4;
          state_nxt     = S_HOLD;
        end else begin
          deliver   = 1'b1;
          pc_nxt    = pc_plus4;
          state_nxt = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_nxt    = i_PCNextD;
          state_nxt = S_REQ;
        end else if (!i_StallD) begin
          deliver       = 1'b1;
          deliver_instr = buf_instr;
          deliver_pc4   = buf_pc4;
          pc_nxt        = buf_pc4;
          state_nxt     = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // State, PC, response buffer and IF/ID register.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      discard   <= 1'b0;
      buf_instr <= NOP_INSTR;
      buf_pc4   <= '0;
      instr_d   <= NOP_INSTR;
      pc4_d     <= '0;
      valid_d   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      discard   <= discard_nxt;
      buf_instr <= buf_instr_nxt;
      buf_pc4   <= buf_pc4_nxt;
      if (i_FlushD) begin
        instr_d <= NOP_INSTR;
        pc4_d   <= '0;
        valid_d <= 1'b0;
      end else if (i_StallD) begin
        instr_d <= instr_d;
        pc4_d   <= pc4_d;
        valid_d <= valid_d;
      end else if (deliver) begin
        instr_d <= deliver_instr;
        pc4_d   <= deliver_pc4;
        valid_d <= 1'b1;
      end else begin
        instr_d <= NOP_INSTR;
        pc4_d   <= '0;
        valid_d <= 1'b0;
      end
    end
  end

  // Request is suppressed while reset is held even though the FSM sits in S_REQ.
  assign o_IMemReq  = mem_req & ~i_RST;
  assign o_IMemAddr = pc;
  assign o_PCF      = pc;
  assign o_InstrD   = instr_d;
  assign o_PCPlus4D = pc4_d;
  assign o_ValidD   = valid_d;

endmodule
